// File: rtl/if_id_fetch_buf.sv
// IF/ID stage: issues fetches to a 1-cycle sync imem, tags returns with their PC, queues up to DEPTH words, feeds ID registers.
// Latency: request to ID output 2 cycles with IFID_BYPASS_EN defined (response bypasses the empty queue), 3 cycles otherwise.
// Backpressure: rdy_f is a credit (queued + in-flight < DEPTH) from registered state only; en=0 stalls ID while IF keeps filling the queue.
// Build option: define IFID_BYPASS_EN to let a response go straight into the ID registers when the queue is empty.
module if_id_fetch_buf #(
    parameter int XLEN  = 32,
    parameter int AW    = 12,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pcf,
    input  logic            req_f,
    output logic            rdy_f,
    output logic            imem_en,
    output logic [AW-1:0]   imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            en,
    input  logic            clear,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic            valid_d
);

    localparam int              PW      = $clog2(DEPTH);
    localparam logic [PW+1:0]   DEPTH_W = (PW+2)'(DEPTH);
    localparam logic [PW:0]     CNT_ONE = (PW+1)'(1);
    localparam logic [PW-1:0]   PTR_ONE = PW'(1);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          queue_q [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW:0]     count;
    logic            inflight_q;
    logic [XLEN-1:0] inflight_pc_q;

    logic            accept;
    logic            q_empty;
    logic            push;
    logic            pop;
    logic            bypass;
    entry_t          resp;
    entry_t          head;

    // Credit counts words already queued plus the one that may still be in flight,
    // so an accepted request always has a slot waiting when its data returns.
    assign rdy_f     = ({1'b0, count} + {{(PW+1){1'b0}}, inflight_q}) < DEPTH_W;
    assign accept    = req_f & rdy_f & ~clear;
    assign imem_en   = accept;
    assign imem_addr = pcf[AW+1:2];

    assign q_empty = (count == '0);
    assign resp    = {inflight_pc_q, imem_rdata};
    assign head    = queue_q[rd_ptr];

    // Pop only when ID advances and something is queued; a flush overrides everything.
    assign pop = ~clear & en & ~q_empty;

`ifdef IFID_BYPASS_EN
    // Empty queue and ID advancing: the returning word skips the queue entirely.
    assign bypass = ~clear & en & q_empty & inflight_q;
`else
    assign bypass = 1'b0;
`endif

    // Any response not flushed and not bypassed lands in the queue.
    assign push = ~clear & inflight_q & ~bypass;

    // Track the single outstanding memory read and the PC it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            inflight_q <= accept;
            if (accept) begin
                inflight_pc_q <= pcf;
            end
        end
    end

    // Queue storage; contents are meaningless outside [rd_ptr, wr_ptr) so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            queue_q[wr_ptr] <= resp;
        end
    end

    // Queue pointers and occupancy; a simultaneous push and pop leaves count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // ID registers: flush zeroes, stall holds, else load head, bypassed word, or a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_d <= '0;
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else if (clear) begin
            instr_d <= '0;
            pc_d    <= '0;
            valid_d <= 1'b0;
        end else if (en) begin
            if (pop) begin
                instr_d <= head.instr;
                pc_d    <= head.pc;
                valid_d <= 1'b1;
            end else if (bypass) begin
                instr_d <= resp.instr;
                pc_d    <= resp.pc;
                valid_d <= 1'b1;
            end else begin
                instr_d <= '0;
                pc_d    <= '0;
                valid_d <= 1'b0;
            end
        end
    end

endmodule
